// File: rtl/bcd_convert_sched.sv
// Binary-to-BCD converter shared by two requesters.
// A round-robin arbiter grants one 16-bit operand at a time; the operand is
// converted by a sequential double-dabble engine (one bit per clock), and the
// five-digit packed BCD result is presented on bcd with a one-cycle done pulse.
module bcd_convert_sched #(
   parameter int FIRST = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req0,
   input  logic [15:0] val0,
   input  logic        req1,
   input  logic [15:0] val1,
   output logic        ack0,
   output logic        ack1,
   output logic        busy,
   output logic        done,
   output logic        done_id,
   output logic [19:0] bcd
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_CONV = 1'b1
   } state_t;

   // Last-grant value that makes FIRST win the first tie after reset.
   localparam logic LAST_RST = (FIRST == 0) ? 1'b1 : 1'b0;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [4:0]  r_cnt;
   logic [15:0] r_opnd;
   logic [19:0] r_acc;
   logic [19:0] r_bcd;
   logic        r_done_id;
   logic        r_done;
   logic        r_ack0;
   logic        r_ack1;
   logic        r_last;
   logic        r_gnt;

   logic        w_req_any;
   logic        w_win;
   logic        w_capture;
   logic        w_last_step;
   logic        w_busy;
   logic [15:0] w_val_sel;
   logic [19:0] w_adj;
   logic [19:0] w_acc_step;

   // Add-3 correction of one BCD digit ahead of the shift.
   function automatic logic [3:0] dd_adj(input logic [3:0] d);
      return (d >= 4'd5) ? (d + 4'd3) : d;
   endfunction

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: IDLE waits for any request, CONV runs 16 steps.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_req_any) w_state_nxt = S_CONV;
         S_CONV:  if (r_cnt == 5'd1) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM decode: round-robin winner, capture strobe, final-step strobe, busy.
   always_comb begin
      w_req_any   = req0 | req1;
      // On a tie the requester not granted last wins; otherwise the lone requester.
      w_win       = (req0 & req1) ? ~r_last : req1;
      w_capture   = (r_state == S_IDLE) & w_req_any;
      w_last_step = (r_state == S_CONV) & (r_cnt == 5'd1);
      w_busy      = (r_state == S_CONV);
      w_val_sel   = w_win ? val1 : val0;
   end

   // One double-dabble step: correct the low four digits, then shift in the operand MSB.
   // The top digit is never corrected; it cannot exceed 6 for a 16-bit operand.
   always_comb begin
      w_adj      = {r_acc[19:16], dd_adj(r_acc[15:12]), dd_adj(r_acc[11:8]),
                    dd_adj(r_acc[7:4]), dd_adj(r_acc[3:0])};
      w_acc_step = (w_adj << 1) | {19'd0, r_opnd[15]};
   end

   // Datapath and handshake registers: capture in IDLE, iterate in CONV, publish on the last step.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt     <= 5'd0;
         r_opnd    <= 16'd0;
         r_acc     <= 20'd0;
         r_bcd     <= 20'd0;
         r_done_id <= 1'b0;
         r_done    <= 1'b0;
         r_ack0    <= 1'b0;
         r_ack1    <= 1'b0;
         r_last    <= LAST_RST;
         r_gnt     <= 1'b0;
      end else begin
         r_ack0 <= w_capture & ~w_win;
         r_ack1 <= w_capture & w_win;
         r_done <= w_last_step;
         if (w_capture) begin
            r_opnd <= w_val_sel;
            r_acc  <= 20'd0;
            r_cnt  <= 5'd16;
            r_gnt  <= w_win;
            r_last <= w_win;
         end else if (r_state == S_CONV) begin
            r_acc  <= w_acc_step;
            r_opnd <= r_opnd << 1;
            r_cnt  <= r_cnt - 5'd1;
            if (w_last_step) begin
               r_bcd     <= w_acc_step;
               r_done_id <= r_gnt;
            end
         end
      end
   end

   assign ack0    = r_ack0;
   assign ack1    = r_ack1;
   assign busy    = w_busy;
   assign done    = r_done;
   assign done_id = r_done_id;
   assign bcd     = r_bcd;

endmodule
